// File: rtl/ksa_seq_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : ksa_seq_addsub_if
// Description : Request/result bundle for the multi-precision add/subtract
//               sequencer. The master side issues start/sub/operands and
//               observes busy/done/result/flags; the slave side is the
//               sequencer itself.
//   Signals   : i_start, i_sub, i_a[W], i_b[W]            (master -> slave)
//               o_busy, o_done, o_result[W], o_cout,
//               o_overflow, o_zero                        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface ksa_seq_addsub_if #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 2
);
    localparam int W = DATA_W * WORDS;

    logic         i_start;
    logic         i_sub;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;
    logic         o_cout;
    logic         o_overflow;
    logic         o_zero;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_result, o_cout, o_overflow, o_zero
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_result, o_cout, o_overflow, o_zero
    );
endinterface
`default_nettype wire

// File: rtl/ksa_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : ksa_adder
// Description : Single-cycle Kogge-Stone adder of width data_size with carry
//               in and carry out.
//   Ports     : a, b [data_size]  operands
//               cin               carry in
//               sum  [data_size]  a + b + cin (truncated)
//               cout              carry out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_adder #(
    parameter int data_size = 32
) (
    input  wire logic [data_size-1:0] a,
    input  wire logic [data_size-1:0] b,
    input  wire logic                 cin,
    output logic      [data_size-1:0] sum,
    output logic                      cout
);
    localparam int LVL = (data_size > 1) ? $clog2(data_size) : 1;

    logic [data_size-1:0] w_p0;
    logic [data_size-1:0] w_g;
    logic [data_size-1:0] w_p;
    logic [data_size-1:0] w_g_nxt;
    logic [data_size-1:0] w_p_nxt;
    logic [data_size:0]   w_carry;

    // Prefix tree: at level lvl each bit merges with the group 2**lvl below.
    // After the tree, w_g[i]/w_p[i] cover bits [i:0], so cin folds in once.
    always_comb begin
        w_p0    = a ^ b;
        w_g     = a & b;
        w_p     = w_p0;
        w_g_nxt = w_g;
        w_p_nxt = w_p;
        for (int lvl = 0; lvl < LVL; lvl++) begin
            w_g_nxt = w_g;
            w_p_nxt = w_p;
            for (int i = (1 << lvl); i < data_size; i++) begin
                w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
                w_p_nxt[i] = w_p[i] & w_p[i - (1 << lvl)];
            end
            w_g = w_g_nxt;
            w_p = w_p_nxt;
        end
        w_carry = {w_g | (w_p & {data_size{cin}}), cin};
        sum     = w_p0 ^ w_carry[data_size-1:0];
        cout    = w_carry[data_size];
    end
endmodule

// ============================================================================
// Module      : ksa_seq_addsub
// Description : Multi-precision add/subtract sequencer. Processes one DATA_W
//               word per cycle, LSW first, through one shared ksa_adder,
//               chaining the carry through a register.
//   Ports     : i_clk, i_rst (async, active-high)
//               bus (slave modport of ksa_seq_addsub_if):
//                 i_start/i_sub/i_a/i_b   request, sampled in IDLE only
//                 o_busy                  state != IDLE
//                 o_done                  one-cycle completion pulse
//                 o_result/o_cout/o_overflow/o_zero  registered result
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_seq_addsub #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    ksa_seq_addsub_if.slave  bus
);
    localparam int W     = DATA_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     acc_q,    acc_d;
    logic             carry_q,  carry_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ov_q,     ov_d;
    logic             zero_q,   zero_d;

    logic [DATA_W-1:0] w_add_a;
    logic [DATA_W-1:0] w_add_b;
    logic [DATA_W-1:0] w_add_sum;
    logic              w_add_cout;

    assign w_add_a = a_q[idx_q*DATA_W +: DATA_W];
    assign w_add_b = b_q[idx_q*DATA_W +: DATA_W];

    ksa_adder #(.data_size(DATA_W)) u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (carry_q),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ov_d     = ov_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    // Subtraction is A + ~B + 1: the +1 enters as the LSW carry.
                    a_d     = bus.i_a;
                    b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
                    carry_d = bus.i_sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[idx_q*DATA_W +: DATA_W] = w_add_sum;
                carry_d = w_add_cout;
                if (idx_q == C_IDX_LAST) begin
                    idx_d    = '0;
                    result_d = acc_d;
                    cout_d   = w_add_cout;
                    // b_q is already inverted for subtract, so one rule covers both.
                    ov_d     = (a_q[W-1] == b_q[W-1]) && (w_add_sum[DATA_W-1] != a_q[W-1]);
                    zero_d   = (acc_d == '0);
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + C_IDX_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ov_q     <= ov_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_result   = result_q;
    assign bus.o_cout     = cout_q;
    assign bus.o_overflow = ov_q;
    assign bus.o_zero     = zero_q;
endmodule
`default_nettype wire

// File: doc/ksa_seq_addsub.md
# ksa_seq_addsub

Multi-cycle, multi-precision add/subtract sequencer built around a single shared `ksa_adder` instance of width `DATA_W`. It processes one `DATA_W` slice per cycle, least-significant first, and chains the carry through a register. This lets the single-cycle core's adder hardware serve `DATA_W*WORDS`-bit operands (e.g. 64-bit arithmetic on a 32-bit adder). It exposes a start/done handshake plus result flags.

## Interface
- `DATA_W`, default 32: width of the internal `ksa_adder` (its `data_size`) and of one processed word.
- `WORDS`, default 2: number of words per operand; legal range ≥1. Full operand width is `W = DATA_W*WORDS`.

- `i_clk`, in, 1: single clock; all state on rising edge.
- `i_rst`, in, 1: reset, asynchronous and active-high.
- `i_start`, in, 1: request; sampled only in IDLE.
- `i_sub`, in, 1: 0 = A+B, 1 = A−B; sampled with `i_start`.
- `i_a`, in, W: operand A; sampled with `i_start`.
- `i_b`, in, W: operand B; sampled with `i_start`.
- `o_busy`, out, 1: high whenever state ≠ IDLE.
- `o_done`, out, 1: one-cycle pulse; result and flags valid from this cycle.
- `o_result`, out, W: final sum/difference; held until the next `o_done`.
- `o_cout`, out, 1: carry out of the MSB. For subtract it is the no-borrow indication: 1 iff A ≥ B unsigned.
- `o_overflow`, out, 1: two's-complement signed overflow of the full W-bit operation.
- `o_zero`, out, 1: `o_result == 0`.

## Operation
- FSM states IDLE, RUN, DONE.
- **IDLE:**
  - On `i_start=1`: latch A into `a_q`.
  - Latch B into `b_q` as `i_sub ? ~i_b : i_b`.
  - Set `carry_q = i_sub`, clear `idx = 0` and the accumulator, then go to RUN.
  - `i_start=0`: stay in IDLE.
- **RUN:**
  - Adder inputs: `a = a_q[idx]`, `b = b_q[idx]`, `cin = carry_q`, where `[idx]` denotes word slice `idx*DATA_W +: DATA_W`.
  - Each edge: write adder `sum` into accumulator word `idx`, set `carry_q <=` adder `cout`, `idx <= idx+1`.
  - When `idx == WORDS-1`:
    - Transfer the full result (including the last word) to `o_result`.
    - Set `o_cout` = adder cout.
    - Set `o_overflow = (a_q_msb == b_q_msb) && (sum_msb != a_q_msb)`, where `b_q` is the already-inverted operand.
    - Set `o_zero` from the full result.
    - Go to DONE.
- **DONE:** `o_done=1` for exactly this cycle, then unconditionally go to IDLE.
- `i_start` in RUN or DONE is ignored: no queuing, and no effect on the latched operands or `i_sub`.
- Input buses may change freely after the sampling edge.
- `idx` counter width is `max(1, $clog2(WORDS))`; it never wraps beyond `WORDS-1`.
- `WORDS=1`: RUN lasts one cycle.
- Adder combinational path is one `DATA_W` KSA only; no W-bit carry chain exists in the design.

## Timing
- Reset (async assert, any state) values:
  - state = IDLE, `o_busy=0`, `o_done=0`.
  - `o_result=0`, `o_cout=0`, `o_overflow=0`, `o_zero=0`.
  - `idx=0`, `carry_q=0`, accumulator = 0.
- Reset asserted mid-RUN or in DONE aborts the operation: no `o_done` pulse, and outputs take their reset values.
- Reset deasserts asynchronously to the FSM but is sampled on edges; first start is accepted on the first edge with `i_rst=0`.
- Start accepted at edge E0. RUN covers edges E1..E_WORDS.
- `o_result` and flags update at edge E_WORDS, and `o_done` is high in the cycle following E_WORDS.
- Latency: result valid `WORDS` cycles after the accepting edge.
- `o_busy` is high from E0 until the edge that leaves DONE (E_WORDS+1).
- Minimum start-to-start spacing: `WORDS+2` cycles.
- Outputs are registered; `o_done` has no combinational path from inputs.

## Test plan
- **Add with carry across words:** `WORDS=2`, A=0x00000000_FFFFFFFF, B=0x00000000_00000001, `i_sub=0`.
  - Required: `o_result`=0x00000001_00000000, cout=0, ov=0, zero=0.
  - `o_done` exactly 2 cycles after the start edge; `o_busy` high for 3 cycles.
- **Subtract with borrow:** A=5, B=7, `i_sub=1`.
  - Required: `o_result`=0xFFFFFFFF_FFFFFFFE, cout=0, ov=0, zero=0.
- **Signed overflow and full wrap:**
  - A=0x7FFFFFFF_FFFFFFFF + 1 → `o_result`=0x80000000_00000000, ov=1, cout=0.
  - A=0xFFFFFFFF_FFFFFFFF + 1 → `o_result`=0, cout=1, ov=0, zero=1.
- **Equal subtract:** A=B=0x12345678_9ABCDEF0, `i_sub=1`.
  - Required: `o_result`=0, zero=1, cout=1, ov=0.
- **Start while busy:** pulse `i_start` with different operands during RUN and again during DONE.
  - Required: both ignored; the first operation's result is unaltered; exactly one `o_done`.
- **Reset mid-operation:** assert `i_rst` between edges while in RUN.
  - Required: `o_busy` and all outputs drop to 0 immediately (async), and no `o_done` follows.
  - A new start after release completes normally.
- **Parameter sweep:** repeat the first scenario with `WORDS=1` and `WORDS=4`.
  - Required: latency equals `WORDS`, and the carry propagates correctly through all words.
